// File: rtl/c499_key_pkg.sv
// c499_key_pkg: shared state encoding and key geometry for the c499 unlock controller
package c499_key_pkg;
  localparam int KEY_W = 16;
  localparam int NIB_W = 4;
  localparam int NUM_BEATS = KEY_W / NIB_W;
  localparam logic [KEY_W-1:0] C499_GOLDEN_KEY = 16'h795E;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_APPLY,
    ST_CHECK,
    ST_UNLOCKED,
    ST_LOCKOUT
  } state_t;
endpackage

// File: rtl/c499_key_ctrl.sv
// c499_key_ctrl: loads the c499 key, runs a known-answer test and gates the functional inputs
module c499_key_ctrl
  import c499_key_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int MAX_FAIL = 3,
  parameter logic [40:0] KAT_IN = 41'h0,
  parameter logic [31:0] KAT_OUT = 32'h0,
  localparam int FW = $clog2(MAX_FAIL + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             relock,
  input  logic             kd_valid,
  input  logic [NIB_W-1:0] kd_data,
  output logic             kd_ready,
  input  logic [40:0]      func_in,
  output logic [40:0]      dut_in,
  output logic [KEY_W-1:0] key_out,
  input  logic [31:0]      dut_out,
  output logic             busy,
  output logic             unlocked,
  output logic             fail,
  output logic             lockout,
  output logic [FW-1:0]    fail_cnt
);
  localparam int BW = $clog2(NUM_BEATS);
  localparam int SW = $clog2(SETTLE + 1);
  state_t state, state_n;
  logic [KEY_W-1:0] key;
  logic [BW-1:0] beat;
  logic [SW-1:0] settle;
  logic match, accept, last_beat, last_settle, check_fail;
  assign kd_ready = state == ST_LOAD;
  assign accept = kd_ready && kd_valid;
  assign last_beat = beat == BW'(NUM_BEATS - 1);
  assign last_settle = settle == SW'(SETTLE - 1);
  assign check_fail = state == ST_CHECK && !relock && !match;
  assign busy = state inside {ST_LOAD, ST_APPLY, ST_CHECK};
  assign unlocked = state == ST_UNLOCKED;
  assign lockout = state == ST_LOCKOUT;
  assign key_out = state inside {ST_APPLY, ST_CHECK, ST_UNLOCKED} ? key : '0;
  assign dut_in = unlocked ? func_in : state inside {ST_APPLY, ST_CHECK} ? KAT_IN : '0;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  // next-state decode; relock takes priority over every decision except in IDLE and LOCKOUT
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:     state_n = start ? ST_LOAD : ST_IDLE;
      ST_LOAD:     state_n = relock ? ST_IDLE : accept && last_beat ? ST_APPLY : ST_LOAD;
      ST_APPLY:    state_n = relock ? ST_IDLE : last_settle ? ST_CHECK : ST_APPLY;
      ST_CHECK:    state_n = relock ? ST_IDLE : match ? ST_UNLOCKED :
                             fail_cnt == FW'(MAX_FAIL - 1) ? ST_LOCKOUT : ST_IDLE;
      ST_UNLOCKED: state_n = relock ? ST_IDLE : ST_UNLOCKED;
      default:     state_n = state;
    endcase
  end
  // key assembly, settle timing, KAT compare and failure accounting
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      key <= '0;
      beat <= '0;
      settle <= '0;
      match <= 1'b0;
      fail <= 1'b0;
      fail_cnt <= '0;
    end else begin
      fail <= check_fail;
      beat <= state != ST_LOAD ? '0 : accept ? beat + 1'b1 : beat;
      settle <= state != ST_APPLY ? '0 : settle + 1'b1;
      if (state == ST_APPLY && last_settle) match <= dut_out == KAT_OUT;
      if (check_fail) fail_cnt <= fail_cnt + 1'b1;
      else if (state == ST_CHECK && state_n == ST_UNLOCKED) fail_cnt <= '0;
      if (state_n == ST_IDLE || state_n == ST_LOCKOUT) key <= '0;
      else if (accept) key[beat*NIB_W +: NIB_W] <= kd_data;
    end
endmodule

// File: tb/tb_c499_key_ctrl.sv
// tb_c499_key_ctrl: randomized self-checking bench for the c499 unlock controller
module tb_c499_key_ctrl;
  import c499_key_pkg::*;
  localparam int MAX_FAIL = 3;
  logic clk = 0, rst = 1, start = 0, relock = 0, kd_valid = 0;
  logic [3:0] kd_data = 0;
  logic [40:0] func_in = 0, dut_in;
  logic [15:0] key_out;
  logic [31:0] dut_out;
  logic kd_ready, busy, unlocked, fail, lockout;
  logic [1:0] fail_cnt;
  int total = 0, bad = 0, model_fails = 0;
  logic [15:0] gold = C499_GOLDEN_KEY;
  always #5 clk = ~clk;
  c499_key_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .relock(relock), .kd_valid(kd_valid),
    .kd_data(kd_data), .kd_ready(kd_ready), .func_in(func_in), .dut_in(dut_in),
    .key_out(key_out), .dut_out(dut_out), .busy(busy), .unlocked(unlocked),
    .fail(fail), .lockout(lockout), .fail_cnt(fail_cnt)
  );
  // stand-in for the locked core: transparent on the low 32 inputs only with the right key
  assign dut_out = dut_in[31:0] ^ {16'h0, key_out ^ gold};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [40:0] rnd41();
    logic [63:0] t = {$urandom(), $urandom()};
    return t[40:0];
  endfunction

  function automatic logic [15:0] wrong_key();
    logic [15:0] k = 16'($urandom());
    return k == gold ? ~k : k;
  endfunction

  task automatic do_reset();
    rst = 1; start = 0; relock = 0; kd_valid = 0;
    step();
    rst = 0;
    step();
  endtask

  task automatic observe(input logic [15:0] k, inout bit leak, inout bit bad_din, inout bit bad_key);
    leak |= kd_ready && key_out != 0;
    bad_din |= !unlocked && dut_in != 0;
    bad_key |= busy && !kd_ready && key_out != k;
  endtask

  task automatic attempt(input logic [15:0] k, input bit gaps, output int edges, output int extra,
                         output bit tmo, output bit leak, output bit bad_din, output bit bad_key,
                         output logic f_end, output logic f_next);
    int n;
    edges = 0; extra = 0; leak = 0; bad_din = 0; bad_key = 0;
    func_in = rnd41(); start = 1;
    step();
    observe(k, leak, bad_din, bad_key);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        n = $urandom_range(1, 2);
        repeat (n) begin
          kd_valid = 0; kd_data = 4'($urandom()); start = 1'($urandom()); func_in = rnd41();
          step(); edges++; extra++;
          observe(k, leak, bad_din, bad_key);
        end
      end
      kd_valid = 1; kd_data = k[4*i +: 4]; start = 1'($urandom()); func_in = rnd41();
      step(); edges++;
      observe(k, leak, bad_din, bad_key);
    end
    kd_valid = 0; start = 0; n = 0;
    while (busy && n < 20) begin
      func_in = rnd41();
      step(); edges++; n++;
      observe(k, leak, bad_din, bad_key);
    end
    tmo = busy;
    f_end = fail;
    step();
    f_next = fail;
  endtask

  task automatic test_reset();
    func_in = rnd41();
    do_reset();
    total++; if ({kd_ready, busy, unlocked, fail, lockout} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {kd_ready, busy, unlocked, fail, lockout}); end
    total++; if (fail_cnt !== 2'd0) begin bad++; $display("FAIL reset_fail_cnt got=%0d exp=0", fail_cnt); end
    total++; if (key_out !== 16'h0) begin bad++; $display("FAIL reset_key_out got=%h exp=0", key_out); end
    total++; if (dut_in !== 41'h0) begin bad++; $display("FAIL reset_dut_in got=%h exp=0", dut_in); end
  endtask

  task automatic test_golden();
    int e, x; bit t, l, d, kb; logic fe, fn;
    attempt(gold, 0, e, x, t, l, d, kb, fe, fn);
    model_fails = 0;
    total++; if (t || e != 7) begin bad++; $display("FAIL golden_latency got=%0d exp=7", e); end
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL golden_unlocked got=%b exp=1", unlocked); end
    total++; if (fail_cnt !== 2'd0 || fe !== 1'b0) begin bad++; $display("FAIL golden_fail got=%0d/%b exp=0/0", fail_cnt, fe); end
    total++; if (key_out !== gold || l || d || kb) begin bad++; $display("FAIL golden_key got=%h leak=%b din=%b key=%b exp=%h", key_out, l, d, kb, gold); end
    func_in = 41'h0; #1;
    total++; if (dut_out !== 32'h0) begin bad++; $display("FAIL golden_zero got=%h exp=0", dut_out); end
    func_in = 41'h1; #1;
    total++; if (dut_out !== 32'h1) begin bad++; $display("FAIL golden_n1 got=%h exp=1", dut_out); end
    for (int i = 0; i < 3; i++) begin
      func_in = rnd41(); #1;
      total++; if (dut_in !== func_in || dut_out !== func_in[31:0]) begin bad++; $display("FAIL golden_func got=%h/%h exp=%h", dut_in, dut_out, func_in); end
    end
    relock = 1; step(); relock = 0;
    total++; if (unlocked !== 1'b0 || key_out !== 16'h0 || dut_in !== 41'h0) begin bad++; $display("FAIL golden_relock got=%b/%h/%h exp=0/0/0", unlocked, key_out, dut_in); end
  endtask

  task automatic test_wrong_key();
    int e, x; bit t, l, d, kb; logic fe, fn;
    attempt(16'h0, 0, e, x, t, l, d, kb, fe, fn);
    model_fails++;
    total++; if (fe !== 1'b1 || fn !== 1'b0) begin bad++; $display("FAIL wrong_fail_pulse got=%b%b exp=10", fe, fn); end
    total++; if (fail_cnt !== 2'(model_fails)) begin bad++; $display("FAIL wrong_fail_cnt got=%0d exp=%0d", fail_cnt, model_fails); end
    total++; if ({busy, unlocked, lockout} !== 3'b0 || key_out !== 16'h0 || dut_in !== 41'h0) begin bad++; $display("FAIL wrong_idle got=%b/%h/%h exp=000/0/0", {busy, unlocked, lockout}, key_out, dut_in); end
    total++; if (t || e != 7) begin bad++; $display("FAIL wrong_latency got=%0d exp=7", e); end
  endtask

  task automatic test_lockout();
    int e, x; bit t, l, d, kb, stuck = 0; logic fe, fn;
    repeat (2) begin
      attempt(wrong_key(), 1, e, x, t, l, d, kb, fe, fn);
      model_fails++;
    end
    total++; if (lockout !== 1'b1 || fe !== 1'b1) begin bad++; $display("FAIL lockout_enter got=%b/%b exp=1/1", lockout, fe); end
    total++; if (fail_cnt !== 2'(MAX_FAIL)) begin bad++; $display("FAIL lockout_fail_cnt got=%0d exp=%0d", fail_cnt, MAX_FAIL); end
    start = 1;
    for (int i = 0; i < 8; i++) begin
      kd_valid = 1; kd_data = gold[4*(i%4) +: 4]; relock = 1'($urandom());
      step();
      stuck |= kd_ready || busy || unlocked || !lockout || key_out != 0;
    end
    start = 0; kd_valid = 0; relock = 0;
    total++; if (stuck) begin bad++; $display("FAIL lockout_hold got=escaped exp=held"); end
    do_reset();
    model_fails = 0;
    total++; if (lockout !== 1'b0 || fail_cnt !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL lockout_rst got=%b/%0d exp=0/0", lockout, fail_cnt); end
  endtask

  task automatic test_stall();
    int e, x; bit t, l = 0, d = 0, kb = 0; logic fe, fn;
    attempt(gold, 1, e, x, t, l, d, kb, fe, fn);
    total++; if (t || e != 7 + x) begin bad++; $display("FAIL stall_latency got=%0d exp=%0d", e, 7 + x); end
    total++; if (unlocked !== 1'b1 || key_out !== gold) begin bad++; $display("FAIL stall_key got=%b/%h exp=1/%h", unlocked, key_out, gold); end
    relock = 1; step(); relock = 0;
    attempt(wrong_key(), 0, e, x, t, l, d, kb, fe, fn);
    model_fails++;
    l = 0; d = 0; kb = 0;
    start = 1; step(); start = 0;
    for (int i = 0; i < 2; i++) begin
      kd_valid = 1; kd_data = gold[4*i +: 4];
      step();
      observe(gold, l, d, kb);
    end
    kd_valid = 0; relock = 1; step(); relock = 0;
    observe(gold, l, d, kb);
    total++; if ({busy, kd_ready, fail} !== 3'b0 || key_out !== 16'h0 || l) begin bad++; $display("FAIL stall_abort got=%b/%h leak=%b exp=000/0", {busy, kd_ready, fail}, key_out, l); end
    total++; if (fail_cnt !== 2'(model_fails)) begin bad++; $display("FAIL stall_fail_cnt got=%0d exp=%0d", fail_cnt, model_fails); end
  endtask

  task automatic test_recover();
    int e, x; bit t, l, d, kb; logic fe, fn;
    attempt(wrong_key(), 0, e, x, t, l, d, kb, fe, fn);
    model_fails++;
    total++; if (fail_cnt !== 2'(model_fails)) begin bad++; $display("FAIL recover_two got=%0d exp=%0d", fail_cnt, model_fails); end
    attempt(gold, 0, e, x, t, l, d, kb, fe, fn);
    model_fails = 0;
    total++; if (unlocked !== 1'b1 || fail_cnt !== 2'd0) begin bad++; $display("FAIL recover_unlock got=%b/%0d exp=1/0", unlocked, fail_cnt); end
    relock = 1; step(); relock = 0;
    total++; if (unlocked !== 1'b0 || key_out !== 16'h0) begin bad++; $display("FAIL recover_relock got=%b/%h exp=0/0", unlocked, key_out); end
  endtask

  task automatic test_async_reset();
    int e, x; bit t, l, d, kb; logic fe, fn;
    start = 1; step(); start = 0;
    for (int i = 0; i < 4; i++) begin
      kd_valid = 1; kd_data = gold[4*i +: 4];
      step();
    end
    kd_valid = 0;
    func_in = rnd41();
    total++; if (busy !== 1'b1 || key_out !== gold) begin bad++; $display("FAIL async_apply got=%b/%h exp=1/%h", busy, key_out, gold); end
    #2 rst = 1;
    #1;
    total++; if ({kd_ready, busy, unlocked, fail, lockout, fail_cnt, key_out, dut_in} !== '0) begin bad++; $display("FAIL async_zero got=%b%b%b%b%b/%0d/%h/%h exp=all0", kd_ready, busy, unlocked, fail, lockout, fail_cnt, key_out, dut_in); end
    step(); rst = 0; step();
    model_fails = 0;
    attempt(gold, 0, e, x, t, l, d, kb, fe, fn);
    total++; if (t || e != 7 || unlocked !== 1'b1) begin bad++; $display("FAIL async_fresh got=%0d/%b exp=7/1", e, unlocked); end
    relock = 1; step(); relock = 0;
  endtask

  task automatic test_random();
    int e, x; bit t, l, d, kb, exp_unl, exp_lock; logic fe, fn; logic [15:0] k;
    for (int it = 0; it < 24; it++) begin
      k = $urandom_range(0, 2) == 0 ? gold : wrong_key();
      attempt(k, 1'($urandom()), e, x, t, l, d, kb, fe, fn);
      exp_unl = k == gold;
      model_fails = exp_unl ? 0 : model_fails + 1;
      exp_lock = model_fails == MAX_FAIL;
      total++; if (t || e != 7 + x) begin bad++; $display("FAIL rnd_latency it=%0d got=%0d exp=%0d", it, e, 7 + x); end
      total++; if (unlocked !== exp_unl || lockout !== exp_lock) begin bad++; $display("FAIL rnd_state it=%0d got=%b%b exp=%b%b", it, unlocked, lockout, exp_unl, exp_lock); end
      total++; if (fail_cnt !== 2'(model_fails)) begin bad++; $display("FAIL rnd_fail_cnt it=%0d got=%0d exp=%0d", it, fail_cnt, model_fails); end
      total++; if (fe !== !exp_unl || fn !== 1'b0) begin bad++; $display("FAIL rnd_pulse it=%0d got=%b%b exp=%b0", it, fe, fn, !exp_unl); end
      total++; if (l || d || kb) begin bad++; $display("FAIL rnd_buses it=%0d got=leak%b din%b key%b exp=000", it, l, d, kb); end
      if (exp_unl) begin relock = 1; step(); relock = 0; end
      if (exp_lock) begin do_reset(); model_fails = 0; end
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_wrong_key();
    test_lockout();
    test_stall();
    test_recover();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
